// File: rtl/cnn_pkg.sv
// Shared CNN address-generation constants and FSM state encoding.
package cnn_pkg;

    localparam int unsigned IMG_W_DEF  = 28;
    localparam int unsigned IMG_H_DEF  = 28;
    localparam int unsigned K_DEF      = 5;
    localparam int unsigned CH_DEF     = 6;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/loop_counter.sv
// Wrapping loop index: counts 0..max on enable; wrap flags the enabled terminal count.
module loop_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = enable && (count == max);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/conv_addr_gen.sv
// Convolution tap address generator: walks c/oy/ox/ky/kx and emits image, weight and output addresses.
// Define CONV_ADDR_GEN_PAD_EN for "same" (zero-padded) convolution; default is "valid".
module conv_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned K      = K_DEF,
    parameter int unsigned CH     = CH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              last_tap,
    output logic              pad_tap,
    output logic              busy,
    output logic              done
);

`ifdef CONV_ADDR_GEN_PAD_EN
    localparam int unsigned PAD   = (K - 1) / 2;
    localparam int unsigned OUT_W = IMG_W;
    localparam int unsigned OUT_H = IMG_H;
`else
    localparam int unsigned PAD   = 0;
    localparam int unsigned OUT_W = IMG_W - K + 1;
    localparam int unsigned OUT_H = IMG_H - K + 1;
`endif
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] PAD_A    = ADDR_W'(PAD);
    localparam logic [ADDR_W-1:0] KK_A     = ADDR_W'(K * K);
    // Linear address of the (oy-PAD, ox-PAD) origin; modular so pad rows/cols wrap harmlessly.
    localparam logic [ADDR_W-1:0] ROW_INIT = ADDR_W'(0) - ADDR_W'(PAD * IMG_W);
    localparam logic [ADDR_W-1:0] LIN_INIT = ROW_INIT - PAD_A;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] kx_cnt, ky_cnt, ox_cnt, oy_cnt, c_cnt;
    logic              kx_wrap, ky_wrap, ox_wrap, oy_wrap, c_wrap;
    logic              acc, tap_pad;

    logic [ADDR_W-1:0] oy_base, win_base, row_base, tap_lin, w_base;

    assign acc = addr_valid && addr_ready;

    loop_counter #(.W(ADDR_W)) u_kx (.clk(clk), .reset(reset), .enable(acc),
        .max(ADDR_W'(K - 1)), .count(kx_cnt), .wrap(kx_wrap));
    loop_counter #(.W(ADDR_W)) u_ky (.clk(clk), .reset(reset), .enable(kx_wrap),
        .max(ADDR_W'(K - 1)), .count(ky_cnt), .wrap(ky_wrap));
    loop_counter #(.W(ADDR_W)) u_ox (.clk(clk), .reset(reset), .enable(ky_wrap),
        .max(ADDR_W'(OUT_W - 1)), .count(ox_cnt), .wrap(ox_wrap));
    loop_counter #(.W(ADDR_W)) u_oy (.clk(clk), .reset(reset), .enable(ox_wrap),
        .max(ADDR_W'(OUT_H - 1)), .count(oy_cnt), .wrap(oy_wrap));
    loop_counter #(.W(ADDR_W)) u_c (.clk(clk), .reset(reset), .enable(oy_wrap),
        .max(ADDR_W'(CH - 1)), .count(c_cnt), .wrap(c_wrap));

`ifdef CONV_ADDR_GEN_PAD_EN
    logic [ADDR_W-1:0] row_sum, col_sum;
    logic              unused_cnt;
    assign row_sum    = oy_cnt + ky_cnt;
    assign col_sum    = ox_cnt + kx_cnt;
    assign tap_pad    = (row_sum < PAD_A) || (row_sum >= ADDR_W'(IMG_H + PAD)) ||
                        (col_sum < PAD_A) || (col_sum >= ADDR_W'(IMG_W + PAD));
    assign unused_cnt = ^c_cnt;
`else
    logic unused_cnt;
    assign tap_pad    = 1'b0;
    assign unused_cnt = ^{c_cnt, oy_cnt, ox_cnt};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (c_wrap) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last_tap   = 1'b0;
        pad_tap    = 1'b0;
        img_addr   = '0;
        unique case (state_q)
            RUN: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                last_tap   = (ky_cnt == ADDR_W'(K - 1)) && (kx_cnt == ADDR_W'(K - 1));
                pad_tap    = tap_pad;
                img_addr   = tap_pad ? '0 : tap_lin;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Row-base accumulators: each loop level adds its stride instead of multiplying.
    always_ff @(posedge clk) begin
        if (reset) begin
            oy_base  <= ROW_INIT;
            win_base <= LIN_INIT;
            row_base <= LIN_INIT;
            tap_lin  <= LIN_INIT;
            w_base   <= '0;
            w_addr   <= '0;
            out_addr <= '0;
        end else if (acc) begin
            if (!kx_wrap) begin
                tap_lin <= tap_lin + ADDR_W'(1);
                w_addr  <= w_addr + ADDR_W'(1);
            end else if (!ky_wrap) begin
                row_base <= row_base + ROW_STEP;
                tap_lin  <= row_base + ROW_STEP;
                w_addr   <= w_addr + ADDR_W'(1);
            end else begin
                out_addr <= c_wrap ? '0 : out_addr + ADDR_W'(1);
                if (!ox_wrap) begin
                    win_base <= win_base + ADDR_W'(1);
                    row_base <= win_base + ADDR_W'(1);
                    tap_lin  <= win_base + ADDR_W'(1);
                    w_addr   <= w_base;
                end else if (!oy_wrap) begin
                    oy_base  <= oy_base + ROW_STEP;
                    win_base <= oy_base + ROW_STEP - PAD_A;
                    row_base <= oy_base + ROW_STEP - PAD_A;
                    tap_lin  <= oy_base + ROW_STEP - PAD_A;
                    w_addr   <= w_base;
                end else begin
                    oy_base  <= ROW_INIT;
                    win_base <= LIN_INIT;
                    row_base <= LIN_INIT;
                    tap_lin  <= LIN_INIT;
                    w_base   <= c_wrap ? '0 : w_base + KK_A;
                    w_addr   <= c_wrap ? '0 : w_base + KK_A;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Scoreboard bench for conv_addr_gen: 4x4/K3/CH2 instance plus a default-parameter instance.
`timescale 1ns/1ps
module tb_conv_addr_gen;

    localparam int AW     = 16;
    localparam int SW     = 4;
    localparam int SK     = 3;
    localparam int SCH    = 2;
    localparam int BUDGET = 700;
`ifdef CONV_ADDR_GEN_PAD_EN
    localparam int SP       = 1;
    localparam int SOW      = SW;
    localparam int HOLD_IMG = 0;
    localparam int LAST_IMG = 0;
    localparam int LAST_OUT = 31;
    localparam int FIRST_PADS = 5;
`else
    localparam int SP       = 0;
    localparam int SOW      = SW - SK + 1;
    localparam int HOLD_IMG = 4;
    localparam int LAST_IMG = 15;
    localparam int LAST_OUT = 7;
    localparam int FIRST_PADS = 0;
`endif
    localparam int STAPS    = SCH * SOW * SOW * SK * SK;
    localparam int LAST_W   = 17;

    typedef struct packed {
        logic [AW-1:0] img;
        logic [AW-1:0] w;
        logic [AW-1:0] out;
        logic          last;
        logic          pad;
    } tap_t;

    logic          clk, reset, start, s_ready;
    logic          s_valid, s_last, s_pad, s_busy, s_done;
    logic [AW-1:0] s_img, s_w, s_out;
    logic          d_start, d_ready;
    logic          d_valid, d_last, d_pad, d_busy, d_done;
    logic [AW-1:0] d_img, d_w, d_out;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    tap_t exp_q[$];
    tap_t got, exp_t;

    int acc_cnt, done_cnt, first_pad, last_acc_cyc, done_cyc;
    int first_img [9];
    int last_img, last_w, last_out;
    int d_taps = 0, d_lasts = 0, d_last_out = 0, d_done_cnt = 0;
    int first_exp [9];

    conv_addr_gen #(.IMG_W(SW), .IMG_H(SW), .K(SK), .CH(SCH), .ADDR_W(AW)) u_small (
        .clk(clk), .reset(reset), .start(start), .addr_ready(s_ready),
        .addr_valid(s_valid), .img_addr(s_img), .w_addr(s_w), .out_addr(s_out),
        .last_tap(s_last), .pad_tap(s_pad), .busy(s_busy), .done(s_done));

    conv_addr_gen u_def (
        .clk(clk), .reset(reset), .start(d_start), .addr_ready(d_ready),
        .addr_valid(d_valid), .img_addr(d_img), .w_addr(d_w), .out_addr(d_out),
        .last_tap(d_last), .pad_tap(d_pad), .busy(d_busy), .done(d_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Reference model: direct multiply-based address formulas for one full pass.
    function automatic void push_model();
        tap_t t;
        for (int c = 0; c < SCH; c++)
            for (int oy = 0; oy < SOW; oy++)
                for (int ox = 0; ox < SOW; ox++)
                    for (int ky = 0; ky < SK; ky++)
                        for (int kx = 0; kx < SK; kx++) begin
                            int r, col;
                            r      = oy + ky - SP;
                            col    = ox + kx - SP;
                            t.pad  = (r < 0) || (r >= SW) || (col < 0) || (col >= SW);
                            t.img  = t.pad ? '0 : AW'(r * SW + col);
                            t.w    = AW'(c * SK * SK + ky * SK + kx);
                            t.out  = AW'(c * SOW * SOW + oy * SOW + ox);
                            t.last = (ky == SK - 1) && (kx == SK - 1);
                            exp_q.push_back(t);
                        end
    endfunction

    // Monitor: pops the scoreboard on every accepted tap and tracks per-pass statistics.
    always @(negedge clk) begin
        if (start && !s_busy && !reset) begin
            acc_cnt = 0; done_cnt = 0; first_pad = 0;
        end
        if (s_valid && s_ready && !reset) begin
            got = {s_img, s_w, s_out, s_last, s_pad};
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tap_unexpected[%0d]: got img=%0d w=%0d out=%0d, expected no tap",
                         acc_cnt, s_img, s_w, s_out);
            end else begin
                exp_t = exp_q.pop_front();
                if (got !== exp_t) begin
                    errors++;
                    $display("FAIL tap[%0d]: got img=%0d w=%0d out=%0d last=%0b pad=%0b, expected img=%0d w=%0d out=%0d last=%0b pad=%0b",
                             acc_cnt, s_img, s_w, s_out, s_last, s_pad,
                             exp_t.img, exp_t.w, exp_t.out, exp_t.last, exp_t.pad);
                end
            end
            if (acc_cnt < 9) begin
                first_img[acc_cnt] = int'(s_img);
                if (s_pad) first_pad++;
            end
            last_img = int'(s_img); last_w = int'(s_w); last_out = int'(s_out);
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (s_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (d_valid && d_ready && !reset) begin
            d_taps++;
            if (d_last) begin
                d_lasts++;
                d_last_out = int'(d_out);
            end
        end
        if (d_done) d_done_cnt++;
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, int'(s_valid), 0);
        chk({tag, "_last"},  int'(s_last), 0);
        chk({tag, "_pad"},   int'(s_pad), 0);
        chk({tag, "_busy"},  int'(s_busy), 0);
        chk({tag, "_done"},  int'(s_done), 0);
        chk({tag, "_img"},   int'(s_img), 0);
        chk({tag, "_w"},     int'(s_w), 0);
        chk({tag, "_out"},   int'(s_out), 0);
    endtask

    // mode 0: plain, 1: backpressure, 2: reset at tap 40, 3: stray starts.
    task automatic run_pass(input int mode);
        int n;
        bit fin, poked;
        exp_q.delete();
        push_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fin = 1'b0; poked = 1'b0; n = 0;
        while (!fin && n < BUDGET) begin
            s_ready = (mode == 1) ? !(n == 3 || n == 4) : 1'b1;
            if (mode == 3 && acc_cnt == 10 && !poked) begin
                start = 1'b1; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && acc_cnt == 40) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check_idle_zero("after_reset");
                repeat (10) @(posedge clk);
                #1;
                chk("no_done_after_reset", done_cnt, 0);
                return;
            end
            @(negedge clk);
            if (mode == 1 && n >= 3 && n <= 5) chk("hold_img", int'(s_img), HOLD_IMG);
            @(posedge clk); #1;
            if (s_done) fin = 1'b1;
            n++;
        end
        chk("pass_finished", int'(fin), 1);
        start = (mode == 3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("tap_count", acc_cnt, STAPS);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, 1);
        chk("done_latency", done_cyc - last_acc_cyc, 1);
        chk("idle_after_pass", int'(s_busy), 0);
        if (mode == 0) begin
            for (int i = 0; i < 9; i++) chk("first_window_img", first_img[i], first_exp[i]);
            chk("first_window_pads", first_pad, FIRST_PADS);
            chk("last_img", last_img, LAST_IMG);
            chk("last_w", last_w, LAST_W);
            chk("last_out", last_out, LAST_OUT);
        end
    endtask

    initial begin
`ifdef CONV_ADDR_GEN_PAD_EN
        first_exp = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
`else
        first_exp = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`endif
        clk = 1'b0; reset = 1'b1; start = 1'b0; s_ready = 1'b1;
        d_start = 1'b0; d_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_pass(0);
        run_pass(1);
        run_pass(2);
        run_pass(0);
        run_pass(3);

`ifndef CONV_ADDR_GEN_PAD_EN
        begin
            int n;
            d_start = 1'b1;
            @(posedge clk); #1;
            d_start = 1'b0;
            n = 0;
            while (!d_done && n < 90000) begin
                @(posedge clk); #1;
                n++;
            end
            chk("default_finished", int'(d_done), 1);
            @(posedge clk); #1;
            chk("default_taps", d_taps, 86400);
            chk("default_last_taps", d_lasts, 3456);
            chk("default_last_out", d_last_out, 3455);
            chk("default_done_count", d_done_cnt, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/conv_addr_gen.md
CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, meaning input image height in pixels.
REQ-003 SHALL have parameter K, default 5, meaning square kernel edge length.
REQ-004 SHALL have parameter CH, default 6, meaning the number of output channels (filters).
REQ-005 SHALL have parameter ADDR_W, default 16, meaning the width of every address output.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit, a one-cycle request to begin a full pass.
REQ-009 SHALL have port addr_ready, input, 1 bit, asserted when downstream accepts the current tap.
REQ-010 SHALL have port addr_valid, output, 1 bit, asserted when the current tap is valid.
REQ-011 SHALL have port img_addr, output, ADDR_W bits, the image memory address of the current tap.
REQ-012 SHALL have port w_addr, output, ADDR_W bits, the weight memory address of the current tap.
REQ-013 SHALL have port out_addr, output, ADDR_W bits, the output-map address of the current window.
REQ-014 SHALL have port last_tap, output, 1 bit, asserted on the final tap of a window (MAC writeback).
REQ-015 SHALL have port pad_tap, output, 1 bit, asserted when the tap lies outside the image.
REQ-016 SHALL have port busy, output, 1 bit, asserted while a pass is in progress.
REQ-017 SHALL have port done, output, 1 bit, a one-cycle pulse at the end of a pass.

Function
REQ-018 SHALL use a state machine with states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when the final tap is accepted; DONE->IDLE after exactly 1 cycle.
REQ-019 SHALL loop in order c (outer), oy, ox, ky, kx (inner); a tap is accepted when addr_valid && addr_ready, and each acceptance advances kx.
REQ-020 SHALL compute img_addr = (oy+ky)*IMG_W + (ox+kx), w_addr = c*K*K + ky*K + kx, and out_addr = c*OUT_H*OUT_W + oy*OUT_W + ox.
REQ-021 SHALL derive addresses incrementally with row-base accumulators; no multipliers are used.
REQ-022 SHALL assert addr_valid in RUN only; the first tap is valid on the cycle after start.
REQ-023 SHALL hold all address outputs and last_tap stable while addr_valid && !addr_ready.
REQ-024 SHALL assert last_tap when ky==K-1 and kx==K-1 together with addr_valid.
REQ-025 SHALL assert busy in RUN and DONE, and SHALL assert done only in DONE.
REQ-026 SHALL ignore start while busy; start coincident with the DONE cycle is also ignored.
REQ-027 SHALL drive all addresses to 0 while not in RUN.
REQ-028 SHALL produce exactly CH*OUT_H*OUT_W*K*K accepted taps per pass.

Reset
REQ-029 SHALL, on reset, set state to IDLE, clear all counters, and drive addr_valid, last_tap, pad_tap, busy, done and all addresses to 0.
REQ-030 SHALL let reset take priority over start and addr_ready, including mid-pass; the pass is abandoned and no done is issued.

Configuration
REQ-031 SHALL, with CONV_ADDR_GEN_PAD_EN defined, use "same" convolution: OUT_W=IMG_W and OUT_H=IMG_H with pad (K-1)/2; a tap outside the image asserts pad_tap and drives img_addr=0.
REQ-032 SHALL, without CONV_ADDR_GEN_PAD_EN, use "valid" convolution: OUT_W=IMG_W-K+1 and OUT_H=IMG_H-K+1, with pad_tap tied to 0.

Structure
REQ-033 SHALL place default image/kernel/channel constants and the state enum typedef in shared package cnn_pkg.
REQ-034 SHALL implement each loop index with sub-module loop_counter (enable, max, count, wrap), instantiated five times.

Verification
REQ-035 SHALL test IMG 4x4, K=3, CH=2, no pad, addr_ready=1: 72 taps occur; the first img_addr is 0,1,2,4,5,6,8,9,10; the last tap has img_addr=15, w_addr=17 and out_addr=7; done pulses on the cycle after the last tap.
REQ-036 SHALL test backpressure: addr_ready toggled 1,0,0,1 from tap 3; img_addr=4 is held for 3 cycles and no tap is skipped or duplicated.
REQ-037 SHALL test reset at tap 40 of the REQ-035 configuration: all outputs are 0 on the next cycle, no done follows, and a new start restarts at img_addr=0.
REQ-038 SHALL test start asserted at tap 10 and during the DONE cycle: the address sequence is unchanged and there is one done per pass.
REQ-039 SHALL test PAD_EN with IMG 4x4, K=3: 16 windows per channel; the first tap asserts pad_tap with img_addr=0, and window (0,0) has 5 pad taps.
REQ-040 SHALL test default parameters without pad: 86400 taps, the last out_addr is 3455, and last_tap count is 3456.
